// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared BCD widths, digit limits and adjust-target encodings
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t ONES_MAX = 4'd9;
    localparam bcd_t TENS_MAX = 4'd5;

    typedef enum logic {
        SEL_MIN = 1'b0,
        SEL_SEC = 1'b1
    } sel_e;

endpackage

// File: rtl/bcd_mod60.sv
// rtl/bcd_mod60.sv - two-digit BCD counter that wraps to 00 after a programmable value
module bcd_mod60
    import stopwatch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  bcd_t wrap_tens,
    input  bcd_t wrap_ones,
    output bcd_t tens,
    output bcd_t ones,
    output logic carry_out
);

    logic at_wrap;

    assign at_wrap   = (tens == wrap_tens) && (ones == wrap_ones);
    assign carry_out = inc & at_wrap;

    // Out-of-range digits fall into the ">= max" branches so they recover to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (at_wrap) begin
                tens <= '0;
                ones <= '0;
            end else if (ones >= ONES_MAX) begin
                ones <= '0;
                tens <= (tens >= TENS_MAX) ? '0 : tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - MM:SS stopwatch advanced by rising edges of the selected slow clock
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int SEC_WRAP = 59,
    parameter int MIN_WRAP = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       which_clk,
    input  logic       adj,
    input  logic       sel,
    input  logic       pause_pulse,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused
);

    localparam bcd_t SEC_WRAP_TENS = bcd_t'(SEC_WRAP / 10);
    localparam bcd_t SEC_WRAP_ONES = bcd_t'(SEC_WRAP % 10);
    localparam bcd_t MIN_WRAP_TENS = bcd_t'(MIN_WRAP / 10);
    localparam bcd_t MIN_WRAP_ONES = bcd_t'(MIN_WRAP % 10);

    logic sync1, sync2, dly;
    logic tick, count_en;
    logic sec_inc, min_inc, sec_carry;
    logic min_carry_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            dly    <= 1'b0;
            paused <= 1'b0;
        end else begin
            sync1 <= which_clk;
            sync2 <= sync1;
            dly   <= sync2;
            if (pause_pulse)
                paused <= ~paused;
        end
    end

    // Gate with the pre-toggle paused value so a tick meeting a pause is kept
    // and a tick meeting a resume is dropped.
    assign tick     = sync2 & ~dly;
    assign count_en = tick & ~paused;

    // In adjust mode the seconds wrap must not ripple into minutes.
    assign sec_inc = count_en & (~adj | (sel == SEL_SEC));
    assign min_inc = count_en & (adj ? (sel == SEL_MIN) : sec_carry);

    bcd_mod60 u_sec (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (sec_inc),
        .wrap_tens (SEC_WRAP_TENS),
        .wrap_ones (SEC_WRAP_ONES),
        .tens      (sec_tens),
        .ones      (sec_ones),
        .carry_out (sec_carry)
    );

    bcd_mod60 u_min (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (min_inc),
        .wrap_tens (MIN_WRAP_TENS),
        .wrap_ones (MIN_WRAP_ONES),
        .tens      (min_tens),
        .ones      (min_ones),
        .carry_out (min_carry_unused)
    );

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - directed self-checking bench for stopwatch_counter
module tb_stopwatch_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       which_clk = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic       pause_pulse = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       paused;
    logic [15:0] mmss;

    int n_cmp = 0;
    int n_err = 0;

    assign mmss = {min_tens, min_ones, sec_tens, sec_ones};

    always #5 clk = ~clk;

    stopwatch_counter #(.SEC_WRAP(59), .MIN_WRAP(59)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .which_clk   (which_clk),
        .adj         (adj),
        .sel         (sel),
        .pause_pulse (pause_pulse),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .paused      (paused)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One which_clk rising edge held high for 'hold' cycles, then low long enough to re-arm.
    task automatic pulse_which(input int hold = 3);
        @(negedge clk);
        which_clk = 1'b1;
        repeat (hold) @(negedge clk);
        which_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse_which();
    endtask

    // Tick whose counting edge coincides with a pause_pulse.
    task automatic tick_with_pause();
        @(negedge clk);
        which_clk = 1'b1;
        repeat (2) @(negedge clk);
        pause_pulse = 1'b1;
        @(negedge clk);
        pause_pulse = 1'b0;
        which_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Tick whose counting edge sees sel changed to new_sel in that same cycle.
    task automatic tick_sel_late(input logic new_sel);
        @(negedge clk);
        which_clk = 1'b1;
        repeat (2) @(negedge clk);
        sel = new_sel;
        @(negedge clk);
        which_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pause_toggle();
        @(negedge clk);
        pause_pulse = 1'b1;
        @(negedge clk);
        pause_pulse = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        adj = 1'b0;
        sel = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic preload(input int mins, input int secs);
        adj = 1'b1;
        sel = 1'b0;
        ticks(mins);
        sel = 1'b1;
        ticks(secs);
        adj = 1'b0;
        sel = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_eq("reset_digits", 32'(mmss), 32'h0000);
        chk_eq("reset_paused", 32'(paused), 32'h0);
        rst_n = 1'b1;

        // First tick latency: digits must change exactly on the 3rd edge.
        @(negedge clk);
        which_clk = 1'b1;
        @(negedge clk);
        chk_eq("lat_e1", 32'(mmss), 32'h0000);
        @(negedge clk);
        chk_eq("lat_e2", 32'(mmss), 32'h0000);
        @(negedge clk);
        chk_eq("lat_e3", 32'(mmss), 32'h0001);
        which_clk = 1'b0;
        repeat (3) @(negedge clk);

        ticks(2);
        chk_eq("run_3", 32'(mmss), 32'h0003);
        pulse_which(12);
        chk_eq("held_high_one_tick", 32'(mmss), 32'h0004);

        ticks(55);
        chk_eq("run_0059", 32'(mmss), 32'h0059);
        ticks(1);
        chk_eq("sec_carry_0100", 32'(mmss), 32'h0100);

        do_reset();
        preload(59, 59);
        chk_eq("preload_5959", 32'(mmss), 32'h5959);
        ticks(1);
        chk_eq("full_wrap_0000", 32'(mmss), 32'h0000);

        adj = 1'b1;
        sel = 1'b0;
        ticks(59);
        chk_eq("adj_min_59", 32'(mmss), 32'h5900);
        ticks(1);
        chk_eq("adj_min_wrap", 32'(mmss), 32'h0000);

        do_reset();
        preload(5, 30);
        chk_eq("preload_0530", 32'(mmss), 32'h0530);
        adj = 1'b1;
        sel = 1'b0;
        ticks(2);
        chk_eq("adj_min_0730", 32'(mmss), 32'h0730);

        do_reset();
        preload(5, 59);
        chk_eq("preload_0559", 32'(mmss), 32'h0559);
        adj = 1'b1;
        sel = 1'b1;
        ticks(1);
        chk_eq("adj_sec_wrap_no_carry", 32'(mmss), 32'h0500);
        sel = 1'b0;
        tick_sel_late(1'b1);
        chk_eq("sel_same_cycle", 32'(mmss), 32'h0501);
        adj = 1'b0;

        do_reset();
        ticks(10);
        chk_eq("run_0010", 32'(mmss), 32'h0010);
        pause_toggle();
        chk_eq("paused_set", 32'(paused), 32'h1);
        ticks(4);
        chk_eq("paused_hold", 32'(mmss), 32'h0010);
        adj = 1'b1;
        sel = 1'b0;
        ticks(1);
        chk_eq("paused_adj_hold", 32'(mmss), 32'h0010);
        adj = 1'b0;
        pause_toggle();
        chk_eq("paused_clear", 32'(paused), 32'h0);
        ticks(1);
        chk_eq("resume_0011", 32'(mmss), 32'h0011);

        tick_with_pause();
        chk_eq("pause_coinc_digits", 32'(mmss), 32'h0012);
        chk_eq("pause_coinc_paused", 32'(paused), 32'h1);
        tick_with_pause();
        chk_eq("resume_coinc_digits", 32'(mmss), 32'h0012);
        chk_eq("resume_coinc_paused", 32'(paused), 32'h0);
        ticks(1);
        chk_eq("after_resume_0013", 32'(mmss), 32'h0013);

        do_reset();
        preload(12, 34);
        chk_eq("preload_1234", 32'(mmss), 32'h1234);
        pause_toggle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("async_rst_digits", 32'(mmss), 32'h0000);
        chk_eq("async_rst_paused", 32'(paused), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(1);
        chk_eq("first_tick_after_rst", 32'(mmss), 32'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
